// File: rtl/replace_pkg.sv
// Definitions shared by the replacement controller and the per-set LRU block.
package replace_pkg;

   localparam int STATE_BITS = 3;

   typedef enum logic [STATE_BITS-1:0] {
      IDLE      = 3'd0,
      SELECT    = 3'd1,
      WRITEBACK = 3'd2,
      FILL      = 3'd3,
      UPDATE    = 3'd4
   } state_t;

   // Ceiling log2; a power-of-two way count gives the exact way-number width.
   function automatic int log2(input int value);
      int bits;
      bits = 0;
      while ((32'sd1 <<< bits) < value) begin
         bits = bits + 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/replace_ctrl_if.sv
// Signal bundle between replace_ctrl (master) and the miss source, LRU and
// memory side (slave).
interface replace_ctrl_if #(
   parameter int WIDTH      = 4,
   parameter int INDEX_BITS = 8
);
   import replace_pkg::*;

   localparam int WAY_BITS = log2(WIDTH);

   logic                  miss_valid;
   logic [INDEX_BITS-1:0] miss_index;
   logic                  miss_ready;
   logic [INDEX_BITS-1:0] current_index;
   logic [WIDTH-1:0]      lru;
   logic [WIDTH-1:0]      valid_bits;
   logic [WIDTH-1:0]      dirty_bits;
   logic                  wb_req;
   logic [WAY_BITS-1:0]   wb_way;
   logic [INDEX_BITS-1:0] wb_index;
   logic                  wb_ack;
   logic                  fill_req;
   logic [WAY_BITS-1:0]   fill_way;
   logic [INDEX_BITS-1:0] fill_index;
   logic                  fill_ack;
   logic [WAY_BITS-1:0]   access;
   logic                  access_valid;
   logic                  done;
   logic [WAY_BITS-1:0]   done_way;

   modport master (
      input  miss_valid, miss_index, lru, valid_bits, dirty_bits, wb_ack, fill_ack,
      output miss_ready, current_index, wb_req, wb_way, wb_index,
             fill_req, fill_way, fill_index, access, access_valid, done, done_way
   );

   modport slave (
      output miss_valid, miss_index, lru, valid_bits, dirty_bits, wb_ack, fill_ack,
      input  miss_ready, current_index, wb_req, wb_way, wb_index,
             fill_req, fill_way, fill_index, access, access_valid, done, done_way
   );

endinterface

// File: rtl/replace_ctrl_way_encoder.sv
// Priority one-hot-to-binary encoder: the lowest set bit wins, all-zero gives 0.
module way_encoder #(
   parameter int WIDTH    = 4,
   parameter int WAY_BITS = 2
) (
   input  logic [WIDTH-1:0]    vec,
   output logic [WAY_BITS-1:0] way
);

   logic found_s;

   // Scan upward; once a set bit is found later bits cannot override it.
   always_comb begin
      found_s = 1'b0;
      way     = '0;
      for (int i = 0; i < WIDTH; i++) begin
         way     = (vec[i] && !found_s) ? WAY_BITS'(i) : way;
         found_s = found_s | vec[i];
      end
   end

endmodule

// File: rtl/replace_ctrl.sv
// Miss replacement controller: picks a victim way, sequences writeback and fill,
// then reports the filled way to the LRU as the most recent access.
module replace_ctrl
   import replace_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int INDEX_BITS = 8
) (
   input  logic           clock,
   input  logic           reset,
   replace_ctrl_if.master bus
);

   localparam int WAY_BITS = log2(WIDTH);

   state_t                state_r;
   state_t                state_next_s;
   logic [INDEX_BITS-1:0] idx_r;
   logic [WAY_BITS-1:0]   victim_r;

   logic [WIDTH-1:0]      invalid_vec_s;
   logic                  any_invalid_s;
   logic [WAY_BITS-1:0]   invalid_way_s;
   logic [WAY_BITS-1:0]   lru_way_s;
   logic [WAY_BITS-1:0]   sel_way_s;
   logic                  victim_dirty_s;
   logic                  accept_s;
   logic                  load_victim_s;

   assign invalid_vec_s = ~bus.valid_bits;
   assign any_invalid_s = |invalid_vec_s;

   way_encoder #(
      .WIDTH    (WIDTH),
      .WAY_BITS (WAY_BITS)
   ) u_invalid_enc (
      .vec (invalid_vec_s),
      .way (invalid_way_s)
   );

   way_encoder #(
      .WIDTH    (WIDTH),
      .WAY_BITS (WAY_BITS)
   ) u_lru_enc (
      .vec (bus.lru),
      .way (lru_way_s)
   );

   // An invalid way never needs writeback, so the dirty test only fires on the LRU choice.
   assign sel_way_s      = any_invalid_s ? invalid_way_s : lru_way_s;
   assign victim_dirty_s = bus.valid_bits[sel_way_s] & bus.dirty_bits[sel_way_s];
   assign accept_s       = (state_r == IDLE) & bus.miss_valid;
   assign load_victim_s  = (state_r == SELECT);

   // State register plus the latched set index and victim way.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r  <= IDLE;
         idx_r    <= '0;
         victim_r <= '0;
      end else begin
         state_r <= state_next_s;
         if (accept_s) begin
            idx_r <= bus.miss_index;
         end else begin
            idx_r <= idx_r;
         end
         if (load_victim_s) begin
            victim_r <= sel_way_s;
         end else begin
            victim_r <= victim_r;
         end
      end
   end

   // Next-state decode; acks are only looked at in their own state.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.miss_valid) begin
               state_next_s = SELECT;
            end else begin
               state_next_s = IDLE;
            end
         end
         SELECT: begin
            if (victim_dirty_s) begin
               state_next_s = WRITEBACK;
            end else begin
               state_next_s = FILL;
            end
         end
         WRITEBACK: begin
            if (bus.wb_ack) begin
               state_next_s = FILL;
            end else begin
               state_next_s = WRITEBACK;
            end
         end
         FILL: begin
            if (bus.fill_ack) begin
               state_next_s = UPDATE;
            end else begin
               state_next_s = FILL;
            end
         end
         UPDATE: begin
            state_next_s = IDLE;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Moore outputs decoded from the registered state, victim and index.
   always_comb begin
      bus.miss_ready    = 1'b0;
      bus.current_index = idx_r;
      bus.wb_req        = 1'b0;
      bus.wb_way        = '0;
      bus.wb_index      = idx_r;
      bus.fill_req      = 1'b0;
      bus.fill_way      = '0;
      bus.fill_index    = idx_r;
      bus.access        = victim_r;
      bus.access_valid  = 1'b0;
      bus.done          = 1'b0;
      bus.done_way      = '0;
      case (state_r)
         IDLE: begin
            bus.miss_ready    = 1'b1;
            bus.current_index = bus.miss_index;
         end
         SELECT: begin
            bus.miss_ready = 1'b0;
         end
         WRITEBACK: begin
            bus.wb_req = 1'b1;
            bus.wb_way = victim_r;
         end
         FILL: begin
            bus.fill_req = 1'b1;
            bus.fill_way = victim_r;
         end
         UPDATE: begin
            bus.access_valid = 1'b1;
            bus.done         = 1'b1;
            bus.done_way     = victim_r;
         end
         default: begin
            bus.miss_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_replace_ctrl.sv
// Self-checking bench for replace_ctrl: a per-cycle expectation queue built from
// the replacement rules, plus literal checks on the directed scenarios.
module tb_replace_ctrl;

   localparam int WIDTH      = 4;
   localparam int INDEX_BITS = 8;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   replace_ctrl_if #(.WIDTH(WIDTH), .INDEX_BITS(INDEX_BITS)) bus ();

   replace_ctrl #(.WIDTH(WIDTH), .INDEX_BITS(INDEX_BITS)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      bit ready;
      int cur;
      bit wb_req;
      int wb_way;
      int wb_index;
      bit fill_req;
      int fill_way;
      int fill_index;
      bit acc_valid;
      int access;
      bit done;
      int done_way;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   model_access = 0;

   int seen_fill_way, seen_fill_index, seen_cur, seen_access, seen_wb_way;
   int wb_cycles, fill_cycles, done_cnt, acc_cnt;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   // Victim rule: lowest invalid way, else lowest set lru bit, else way 0.
   function automatic int model_victim(input logic [3:0] v, input logic [3:0] l);
      for (int i = 0; i < WIDTH; i++) if (!v[i]) return i;
      for (int i = 0; i < WIDTH; i++) if (l[i]) return i;
      return 0;
   endfunction

   function automatic exp_t base(input int cur);
      exp_t e;
      e.ready = 1'b0; e.cur = cur;
      e.wb_req = 1'b0; e.wb_way = 0; e.wb_index = 0;
      e.fill_req = 1'b0; e.fill_way = 0; e.fill_index = 0;
      e.acc_valid = 1'b0; e.access = model_access; e.done = 1'b0; e.done_way = 0;
      return e;
   endfunction

   task automatic clear_seen();
      seen_fill_way = -1; seen_fill_index = -1; seen_cur = -1; seen_access = -1; seen_wb_way = -1;
      wb_cycles = 0; fill_cycles = 0; done_cnt = 0; acc_cnt = 0;
   endtask

   task automatic step(input exp_t e);
      exp_q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   task automatic busy_noise();
      bus.miss_valid = 1'($urandom_range(0, 1));
      bus.miss_index = 8'($urandom_range(0, 255));
   endtask

   // Compare process: DUT outputs against the queued expectation for this cycle.
   always @(negedge clock) begin
      exp_t e;
      if (bus.fill_req) begin
         seen_fill_way = int'(bus.fill_way); seen_fill_index = int'(bus.fill_index);
         seen_cur = int'(bus.current_index); fill_cycles++;
      end
      if (bus.wb_req) begin
         seen_wb_way = int'(bus.wb_way); wb_cycles++;
      end
      if (bus.access_valid) begin
         seen_access = int'(bus.access); acc_cnt++;
      end
      if (bus.done) done_cnt++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("miss_ready", int'(bus.miss_ready), int'(e.ready));
         chk("current_index", int'(bus.current_index), e.cur);
         chk("wb_req", int'(bus.wb_req), int'(e.wb_req));
         chk("fill_req", int'(bus.fill_req), int'(e.fill_req));
         chk("access_valid", int'(bus.access_valid), int'(e.acc_valid));
         chk("done", int'(bus.done), int'(e.done));
         chk("access", int'(bus.access), e.access);
         if (e.wb_req) begin
            chk("wb_way", int'(bus.wb_way), e.wb_way);
            chk("wb_index", int'(bus.wb_index), e.wb_index);
         end
         if (e.fill_req) begin
            chk("fill_way", int'(bus.fill_way), e.fill_way);
            chk("fill_index", int'(bus.fill_index), e.fill_index);
         end
         if (e.done) chk("done_way", int'(bus.done_way), e.done_way);
      end
   end

   task automatic run_miss(input int idx, input logic [3:0] v, input logic [3:0] d,
                           input logic [3:0] l, input int wb_wait, input int fill_wait,
                           input int gap);
      exp_t e;
      int   vic;
      bit   dirty;
      int   rnd_idx;
      vic   = model_victim(v, l);
      dirty = v[vic] && d[vic];
      bus.valid_bits = v; bus.dirty_bits = d; bus.lru = l;
      for (int g = 0; g < gap; g++) begin
         rnd_idx = $urandom_range(0, 255);
         bus.miss_valid = 1'b0; bus.miss_index = rnd_idx[7:0];
         bus.wb_ack = 1'($urandom_range(0, 1)); bus.fill_ack = 1'($urandom_range(0, 1));
         e = base(rnd_idx); e.ready = 1'b1; step(e);
      end
      bus.miss_valid = 1'b1; bus.miss_index = idx[7:0];
      bus.wb_ack = 1'($urandom_range(0, 1)); bus.fill_ack = 1'($urandom_range(0, 1));
      e = base(idx); e.ready = 1'b1; step(e);
      busy_noise();
      e = base(idx); step(e);
      model_access = vic;
      if (dirty) begin
         for (int k = 1; k <= wb_wait; k++) begin
            busy_noise();
            bus.wb_ack = (k == wb_wait); bus.fill_ack = 1'($urandom_range(0, 1));
            e = base(idx); e.wb_req = 1'b1; e.wb_way = vic; e.wb_index = idx; step(e);
         end
      end
      for (int k = 1; k <= fill_wait; k++) begin
         busy_noise();
         bus.fill_ack = (k == fill_wait); bus.wb_ack = 1'($urandom_range(0, 1));
         e = base(idx); e.fill_req = 1'b1; e.fill_way = vic; e.fill_index = idx; step(e);
      end
      busy_noise();
      bus.wb_ack = 1'($urandom_range(0, 1)); bus.fill_ack = 1'($urandom_range(0, 1));
      e = base(idx); e.acc_valid = 1'b1; e.done = 1'b1; e.done_way = vic; step(e);
      bus.miss_valid = 1'b0; bus.wb_ack = 1'b0; bus.fill_ack = 1'b0;
   endtask

   initial begin
      exp_t e;
      reset = 1'b1;
      bus.miss_valid = 1'b0; bus.miss_index = 8'd0; bus.lru = 4'd0;
      bus.valid_bits = 4'd0; bus.dirty_bits = 4'd0; bus.wb_ack = 1'b0; bus.fill_ack = 1'b0;
      clear_seen();

      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         bus.miss_index = 8'(10 + 7 * i);
         @(negedge clock);
         chk("rst miss_ready", int'(bus.miss_ready), 1);
         chk("rst current_index", int'(bus.current_index), 10 + 7 * i);
         chk("rst wb_req", int'(bus.wb_req), 0);
         chk("rst fill_req", int'(bus.fill_req), 0);
         chk("rst access_valid", int'(bus.access_valid), 0);
         chk("rst done", int'(bus.done), 0);
         chk("rst access", int'(bus.access), 0);
         chk("rst ways", int'({bus.wb_way, bus.fill_way, bus.done_way}), 0);
      end
      @(posedge clock); #1;
      reset = 1'b0;

      // Clean LRU victim.
      clear_seen();
      run_miss(5, 4'b1111, 4'b0000, 4'b1000, 1, 2, 1);
      chk("s1 fill_way", seen_fill_way, 3);
      chk("s1 fill_index", seen_fill_index, 5);
      chk("s1 current_index", seen_cur, 5);
      chk("s1 access", seen_access, 3);
      chk("s1 wb cycles", wb_cycles, 0);
      chk("s1 done pulses", done_cnt, 1);
      chk("s1 access_valid pulses", acc_cnt, 1);

      // Invalid way preferred over the LRU choice, even if marked dirty.
      clear_seen();
      run_miss(9, 4'b1011, 4'b0100, 4'b0001, 1, 1, 0);
      chk("s2 fill_way", seen_fill_way, 2);
      chk("s2 access", seen_access, 2);
      chk("s2 wb cycles", wb_cycles, 0);

      // Dirty victim with a three-cycle writeback.
      clear_seen();
      run_miss(33, 4'b1111, 4'b0010, 4'b0010, 3, 1, 0);
      chk("s3 wb cycles", wb_cycles, 3);
      chk("s3 wb_way", seen_wb_way, 1);
      chk("s3 fill_way", seen_fill_way, 1);
      chk("s3 access", seen_access, 1);

      // Reset in the middle of a writeback.
      clear_seen();
      bus.valid_bits = 4'b1111; bus.dirty_bits = 4'b0010; bus.lru = 4'b0010;
      bus.miss_valid = 1'b1; bus.miss_index = 8'd42;
      e = base(42); e.ready = 1'b1; step(e);
      bus.miss_valid = 1'b0;
      e = base(42); step(e);
      model_access = 1;
      bus.wb_ack = 1'b0;
      e = base(42); e.wb_req = 1'b1; e.wb_way = 1; e.wb_index = 42; step(e);
      #1;
      chk("s4 wb_req before reset", int'(bus.wb_req), 1);
      #1 reset = 1'b1;
      #1;
      chk("s4 wb_req on reset", int'(bus.wb_req), 0);
      chk("s4 fill_req on reset", int'(bus.fill_req), 0);
      chk("s4 miss_ready on reset", int'(bus.miss_ready), 1);
      chk("s4 access_valid on reset", int'(bus.access_valid), 0);
      chk("s4 access on reset", int'(bus.access), 0);
      chk("s4 current_index on reset", int'(bus.current_index), 42);
      @(posedge clock); #1;
      reset = 1'b0;
      model_access = 0;
      for (int i = 0; i < 2; i++) begin
         e = base(42); e.ready = 1'b1; step(e);
      end
      chk("s4 wb cycles", wb_cycles, 1);
      chk("s4 no access_valid", acc_cnt, 0);
      chk("s4 no done", done_cnt, 0);

      // lru all-zero with every way valid.
      clear_seen();
      run_miss(77, 4'b1111, 4'b0000, 4'b0000, 1, 1, 0);
      chk("b1 fill_way", seen_fill_way, 0);
      chk("b1 access", seen_access, 0);

      // Acks pulsed while idle are ignored.
      clear_seen();
      bus.miss_valid = 1'b0; bus.miss_index = 8'd99; bus.fill_ack = 1'b1; bus.wb_ack = 1'b1;
      e = base(99); e.ready = 1'b1; step(e);
      bus.fill_ack = 1'b0; bus.wb_ack = 1'b0;
      e = base(99); e.ready = 1'b1; step(e);
      chk("b2 miss_ready", int'(bus.miss_ready), 1);
      chk("b2 done", done_cnt, 0);
      chk("b2 fill cycles", fill_cycles, 0);

      // Randomised misses.
      for (int n = 0; n < 40; n++) begin
         logic [3:0] v;
         v = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) v = 4'b1111;
         run_miss($urandom_range(0, 255), v, 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), $urandom_range(1, 3),
                  $urandom_range(1, 3), $urandom_range(0, 2));
      end

      @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/replace_ctrl.md
# replace_ctrl

Cache miss replacement controller that sits directly upstream of the per-set `LRU` block. It accepts a miss for a set index and drives `current_index` to the LRU. It chooses a victim way, preferring an invalid way and otherwise the LRU's one-hot `lru` output. It sequences an optional dirty writeback, then the line fill, then reports the filled way back to the LRU as the most recent access via `access`/`access_valid`.

## Interface
- `WIDTH`, 4: number of ways; power of two, ≥2.
- `INDEX_BITS`, 8: set index width.
- `WAY_BITS`, log2(WIDTH): way number width; derived, not overridden.

- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `miss_valid`  in  1  miss request.
- `miss_index`  in  INDEX_BITS  set index of the miss.
- `miss_ready`  out  1  controller can accept a miss.
- `current_index`  out  INDEX_BITS  set index presented to the LRU.
- `lru`  in  WIDTH  one-hot LRU way for `current_index`, from the LRU.
- `valid_bits`  in  WIDTH  per-way valid bits of the set at `current_index`.
- `dirty_bits`  in  WIDTH  per-way dirty bits of the same set.
- `wb_req`  out  1  writeback request.
- `wb_way`  out  WAY_BITS  way to write back.
- `wb_index`  out  INDEX_BITS  set index to write back.
- `wb_ack`  in  1  writeback complete.
- `fill_req`  out  1  fill request.
- `fill_way`  out  WAY_BITS  way to fill.
- `fill_index`  out  INDEX_BITS  set index to fill.
- `fill_ack`  in  1  fill complete.
- `access`  out  WAY_BITS  way number to the LRU.
- `access_valid`  out  1  one-cycle LRU update strobe.
- `done`  out  1  one-cycle miss-complete pulse.
- `done_way`  out  WAY_BITS  way filled; valid only while `done`=1.

## Operation
- The FSM has five states: IDLE, SELECT, WRITEBACK, FILL, UPDATE. Outputs are Moore, decoded from registered state, victim and index.
- IDLE
  - `miss_ready`=1 and `current_index`=`miss_index`.
  - When `miss_valid`&`miss_ready`: latch `miss_index` into `idx_q` and go to SELECT.
- In all states other than IDLE, `current_index`=`idx_q`.
- SELECT (one cycle): sample `valid_bits`, `dirty_bits` and `lru`.
  - Any valid bit 0: victim = lowest-numbered invalid way.
  - All valid: victim = binary of the `lru` bit that is set.
  - `lru` not one-hot: use the lowest set bit; if `lru`=0, use way 0.
  - Victim valid and dirty: go to WRITEBACK. Otherwise go to FILL.
- WRITEBACK
  - `wb_req`=1, `wb_way`=victim, `wb_index`=`idx_q`.
  - Held until `wb_ack`=1 is sampled; then go to FILL.
- FILL
  - `fill_req`=1, `fill_way`=victim, `fill_index`=`idx_q`.
  - Held until `fill_ack`; then go to UPDATE.
- UPDATE (one cycle)
  - `access_valid`=1, `access`=victim, `done`=1, `done_way`=victim.
  - Next state is IDLE.
- `wb_ack` or `fill_ack` outside its own state is ignored.
- `access` holds the last victim when `access_valid`=0.

## Timing
- Reset values (effective asynchronously): state IDLE, `idx_q`=0, victim=0, `miss_ready`=1, `current_index` follows `miss_index`. All of `wb_req`, `fill_req`, `access_valid`, `done`, `access`, `wb_way`, `fill_way`, `done_way` are 0.
- Minimum latency, clean victim with `fill_ack` in the first FILL cycle:
  - T: accept.
  - T+1: SELECT.
  - T+2: FILL.
  - T+3: UPDATE.
  - T+4: `miss_ready`=1.
- A dirty victim adds one WRITEBACK cycle per cycle spent waiting for `wb_ack`, minimum 1.
- The request/ack handshake is level-held request with a single-cycle ack; an ack in the first request cycle is legal.
- Reset mid-operation, in any state: return to IDLE and drop `wb_req`/`fill_req` immediately. No LRU update is issued. Downstream must abandon the transfer.
- At most one miss is in flight. `miss_valid` while busy is held off by `miss_ready`=0.

## Structure
- A shared package `replace_pkg` holds:
  - state encoding constants (IDLE=0 … UPDATE=4, 3 bits);
  - the `log2` function used for `WAY_BITS`, shared with `LRU`.
- One sub-module, `way_encoder`: a priority one-hot-to-binary encoder, lowest set bit wins, 0 maps to 0.
  - Instantiated twice: on `~valid_bits` and on `lru`.

## Test plan
- Reset held 5 cycles, then released -> `miss_ready`=1; `wb_req`=`fill_req`=`access_valid`=`done`=0 throughout.
- WIDTH=4. Stimulus: `valid_bits`=4'b1111, `dirty_bits`=0, `lru`=4'b1000, miss index 5, `fill_ack` one cycle after `fill_req` rises.
  - Required: `current_index`=5.
  - No `wb_req`.
  - `fill_req` with `fill_way`=3, `fill_index`=5.
  - Then `access`=3 with `access_valid` and `done` high for exactly 1 cycle.
- `valid_bits`=4'b1011, `lru`=4'b0001 -> victim way 2: `fill_way`=2, `access`=2.
- `valid_bits`=4'b1111, `lru`=4'b0010, `dirty_bits`=4'b0010, `wb_ack` after 3 cycles.
  - Required: `wb_req` held 3 cycles with `wb_way`=1.
  - Then `fill_req`, `fill_way`=1, then `access`=1.
- Same set-up as the previous scenario, with `reset` asserted mid-WRITEBACK -> `wb_req` falls immediately, `miss_ready`=1, no `access_valid`.
- Two boundary checks:
  - `lru`=0 with all ways valid -> victim way 0.
  - `fill_ack` pulsed in IDLE -> no state change, no `done`.
